// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-master memory bus arbiter: FSM states,
// owner IDs and one-hot grant encodings.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  function automatic logic [1:0] owner_grant(input owner_t o);
    return (o == OWN_M1) ? GRANT_M1 : GRANT_M0;
  endfunction

  function automatic owner_t other_owner(input owner_t o);
    return (o == OWN_M1) ? OWN_M0 : OWN_M1;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_pick2.sv
// Combinational 2-way picker: an unexpired lock wins if its owner requests,
// otherwise round-robin on a tie, otherwise the lone requester.
module mem_bus_arbiter_rr_pick2
  import mem_bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last,
  input  logic       lock_active,
  input  owner_t     lock_owner,
  input  logic       lock_expired,
  output owner_t     pick,
  output logic       valid
);

  always_comb begin
    pick  = OWN_M0;
    valid = |req;
    if (lock_active && !lock_expired && req[lock_owner]) begin
      pick = lock_owner;
    end else if (&req) begin
      pick = other_owner(last);
    end else if (req[1]) begin
      pick = OWN_M1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one synchronous-read memory port between two requesters using a
// round-robin grant with a bounded lock; one access per IDLE/ISSUE/RESP pass.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_lock,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] address,
  output logic              write,
  output logic [DATA_W-1:0] to_memory,
  input  logic [DATA_W-1:0] from_memory,
  output logic [1:0]        grant
);

  localparam int              CNT_W   = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

  state_t            state, state_nxt;
  owner_t            owner, load_sel;
  owner_t            last_grant, last_nxt;
  owner_t            lock_owner, lo_nxt;
  owner_t            pick;
  logic              pick_valid;
  logic              load;
  logic              cap_we, cap_lock;
  logic              lock_active, la_nxt;
  logic [CNT_W-1:0]  lock_cnt, lc_nxt;
  logic              lock_expired;
  logic [1:0]        grant_nxt;
  logic [1:0]        req;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we, sel_lock;
  logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;

  assign req          = {m1_req, m0_req};
  assign lock_expired = (lock_cnt >= CNT_MAX);

  mem_bus_arbiter_rr_pick2 u_pick (
    .req          (req),
    .last         (last_grant),
    .lock_active  (lock_active),
    .lock_owner   (lock_owner),
    .lock_expired (lock_expired),
    .pick         (pick),
    .valid        (pick_valid)
  );

  // Next-state logic; a pick that bypasses the lock (expired or owner idle)
  // restarts the lock count so the bound applies per run of locked grants.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_sel  = owner;
    grant_nxt = grant;
    last_nxt  = last_grant;
    la_nxt    = lock_active;
    lo_nxt    = lock_owner;
    lc_nxt    = lock_cnt;

    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          state_nxt = ST_ISSUE;
          load      = 1'b1;
          load_sel  = pick;
          if (lock_expired) begin
            lc_nxt = '0;
          end
          if (lock_active && pick != lock_owner) begin
            la_nxt = 1'b0;
            lc_nxt = '0;
          end
        end
      end
      ST_ISSUE: begin
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        last_nxt = owner;
        if (cap_lock) begin
          la_nxt = 1'b1;
          lo_nxt = owner;
          lc_nxt = lock_expired ? lock_cnt : lock_cnt + 1'b1;
        end else begin
          la_nxt = 1'b0;
          lc_nxt = '0;
        end
        if (req[other_owner(owner)] && !(la_nxt && lc_nxt < CNT_MAX)) begin
          state_nxt = ST_ISSUE;
          load      = 1'b1;
          load_sel  = other_owner(owner);
          la_nxt    = 1'b0;
          lc_nxt    = '0;
        end else begin
          state_nxt = ST_IDLE;
          grant_nxt = GRANT_NONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = GRANT_NONE;
      end
    endcase

    if (load) begin
      grant_nxt = owner_grant(load_sel);
    end
  end

  always_comb begin
    sel_addr  = m0_addr;
    sel_wdata = m0_wdata;
    sel_we    = m0_we;
    sel_lock  = m0_lock;
    if (load_sel == OWN_M1) begin
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
      sel_we    = m1_we;
      sel_lock  = m1_lock;
    end
  end

  // The captured address/data double as the memory-side outputs, so they
  // naturally hold their last value outside ISSUE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      owner       <= OWN_M0;
      address     <= '0;
      to_memory   <= '0;
      cap_we      <= 1'b0;
      cap_lock    <= 1'b0;
      grant       <= GRANT_NONE;
      last_grant  <= OWN_M1;
      lock_active <= 1'b0;
      lock_owner  <= OWN_M0;
      lock_cnt    <= '0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      last_grant  <= last_nxt;
      lock_active <= la_nxt;
      lock_owner  <= lo_nxt;
      lock_cnt    <= lc_nxt;
      if (load) begin
        owner     <= load_sel;
        address   <= sel_addr;
        to_memory <= sel_wdata;
        cap_we    <= sel_we;
        cap_lock  <= sel_lock;
      end
      if (state == ST_RESP && !cap_we) begin
        if (owner == OWN_M0) begin
          m0_rdata_q <= from_memory;
        end else begin
          m1_rdata_q <= from_memory;
        end
      end
    end
  end

  // Read data arrives the cycle after the address, i.e. during RESP, so it is
  // forwarded straight through in the ack cycle and held afterwards.
  assign write    = (state == ST_ISSUE) && cap_we;
  assign m0_ack   = (state == ST_RESP) && (owner == OWN_M0);
  assign m1_ack   = (state == ST_RESP) && (owner == OWN_M1);
  assign m0_rdata = (m0_ack && !cap_we) ? from_memory : m0_rdata_q;
  assign m1_rdata = (m1_ack && !cap_we) ? from_memory : m1_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a synchronous-read memory model;
// expected values are hand-derived from the arbiter's timing and lock rules.
module tb_mem_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       m0_req = 1'b0, m0_we = 1'b0, m0_lock = 1'b0;
  logic [7:0] m0_addr = '0, m0_wdata = '0;
  logic       m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
  logic [7:0] m1_addr = '0, m1_wdata = '0;
  logic       m0_ack, m1_ack, write;
  logic [7:0] m0_rdata, m1_rdata, address, to_memory;
  logic [7:0] from_memory;
  logic [1:0] grant;

  logic       pre_we = 1'b0;
  logic [7:0] pre_addr = '0, pre_data = '0;
  logic [7:0] mem [0:255];

  int n_checks = 0;
  int n_pass   = 0;

  mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_LOCK(8)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_lock(m0_lock), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .address(address), .write(write), .to_memory(to_memory),
    .from_memory(from_memory), .grant(grant)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory: data for the address seen at an edge appears
  // after that edge; the backdoor port preloads contents.
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (write) mem[address] <= to_memory;
    from_memory <= mem[address];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    if (observed === expected) n_pass++;
    else $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input int master, input logic req, input logic we,
                               input logic [7:0] addr, input logic [7:0] wdata,
                               input logic lock);
    if (master == 0) begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_lock = lock;
    end else begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_lock = lock;
    end
  endtask

  task automatic preload(input logic [7:0] addr, input logic [7:0] data);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = addr; pre_data = data;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic single_access(input int master, input logic we, input logic [7:0] addr,
                               input logic [7:0] wdata, input logic [7:0] exp_rdata);
    logic [1:0] own;
    own = (master == 0) ? 2'b01 : 2'b10;
    @(negedge clk);
    applyStimulus(master, 1'b1, we, addr, wdata, 1'b0);
    @(negedge clk);
    checkOutput("issue_addr", address, addr);
    checkOutput("issue_write", write, we);
    if (we) checkOutput("issue_wdata", to_memory, wdata);
    checkOutput("issue_grant", grant, own);
    checkOutput("issue_ack", {m1_ack, m0_ack}, 2'b00);
    @(negedge clk);
    checkOutput("resp_ack", {m1_ack, m0_ack}, own);
    checkOutput("resp_write", write, 1'b0);
    if (!we) checkOutput("resp_rdata", (master == 0) ? m0_rdata : m1_rdata, exp_rdata);
    applyStimulus(master, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    checkOutput("idle_ack", {m1_ack, m0_ack}, 2'b00);
    checkOutput("idle_grant", grant, 2'b00);
  endtask

  initial begin
    int n_acks;
    int run;
    int max_run;
    logic ack_seq [0:31];

    // Reset state and memory preload
    preload(8'h10, 8'h5A);
    preload(8'h40, 8'h11);
    checkOutput("rst_grant", grant, 2'b00);
    checkOutput("rst_write", write, 1'b0);
    checkOutput("rst_ack", {m1_ack, m0_ack}, 2'b00);
    checkOutput("rst_address", address, 8'h00);
    checkOutput("rst_to_memory", to_memory, 8'h00);
    checkOutput("rst_rdata", {m1_rdata, m0_rdata}, 16'h0000);
    @(negedge clk);
    reset = 1'b1;

    // Single read and single write
    single_access(0, 1'b0, 8'h10, 8'h00, 8'h5A);
    checkOutput("hold_rdata", m0_rdata, 8'h5A);
    single_access(1, 1'b1, 8'h20, 8'hC3, 8'h00);
    checkOutput("mem_written", mem[8'h20], 8'hC3);
    checkOutput("m1_rdata_after_write", m1_rdata, 8'h00);

    // Simultaneous requests after reset: m0 first, then strict alternation
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
    applyStimulus(1, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checkOutput("rr_ack", {m1_ack, m0_ack},
                  (k % 2 != 0) ? 2'b00 : (((k / 2) % 2 == 1) ? 2'b01 : 2'b10));
      checkOutput("rr_grant", grant, (((k + 1) / 2) % 2 == 1) ? 2'b01 : 2'b10);
      if (m0_ack) checkOutput("rr_m0_rdata", m0_rdata, 8'h5A);
      if (m1_ack) checkOutput("rr_m1_rdata", m1_rdata, 8'hC3);
    end
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    applyStimulus(1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    checkOutput("rr_end_grant", grant, 2'b00);

    // m1 locked writes vs m0 reads: m0, 8x m1, m0, 8x m1, m0
    applyStimulus(0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
    applyStimulus(1, 1'b1, 1'b1, 8'h30, 8'h77, 1'b1);
    n_acks = 0;
    for (int cyc = 0; cyc < 300 && n_acks < 19; cyc++) begin
      @(negedge clk);
      if (m0_ack || m1_ack) begin
        ack_seq[n_acks] = m1_ack;
        n_acks++;
        if (n_acks == 19) begin
          applyStimulus(0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
          applyStimulus(1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        end
      end
    end
    checkOutput("lock_ack_count", n_acks, 19);
    run = 0;
    max_run = 0;
    for (int i = 0; i < n_acks; i++) begin
      checkOutput("lock_seq", ack_seq[i], (i == 0 || i == 9 || i == 18) ? 1'b0 : 1'b1);
      run = ack_seq[i] ? run + 1 : 0;
      if (run > max_run) max_run = run;
    end
    checkOutput("lock_max_run", max_run, 8);
    @(negedge clk);
    checkOutput("lock_end_grant", grant, 2'b00);

    // Locked m1 goes idle while m0 requests
    applyStimulus(1, 1'b1, 1'b0, 8'h20, 8'h00, 1'b1);
    @(negedge clk);
    checkOutput("lk6_grant_m1", grant, 2'b10);
    @(negedge clk);
    checkOutput("lk6_m1_ack", {m1_ack, m0_ack}, 2'b10);
    checkOutput("lk6_m1_rdata", m1_rdata, 8'hC3);
    applyStimulus(1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
    @(negedge clk);
    checkOutput("lk6_idle_grant", grant, 2'b00);
    checkOutput("lk6_lock_held", dut.lock_active, 1'b1);
    @(negedge clk);
    checkOutput("lk6_grant_m0", grant, 2'b01);
    checkOutput("lk6_addr", address, 8'h10);
    checkOutput("lk6_lock_cleared", dut.lock_active, 1'b0);
    @(negedge clk);
    checkOutput("lk6_m0_ack", {m1_ack, m0_ack}, 2'b01);
    checkOutput("lk6_m0_rdata", m0_rdata, 8'h5A);
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);

    // Reset in the middle of a write's ISSUE cycle
    applyStimulus(0, 1'b1, 1'b1, 8'h40, 8'h99, 1'b0);
    @(negedge clk);
    checkOutput("rst5_write_before", write, 1'b1);
    checkOutput("rst5_addr_before", address, 8'h40);
    reset = 1'b0;
    #1;
    checkOutput("rst5_write_drop", write, 1'b0);
    checkOutput("rst5_grant", grant, 2'b00);
    checkOutput("rst5_ack", {m1_ack, m0_ack}, 2'b00);
    @(negedge clk);
    checkOutput("rst5_no_ack", {m1_ack, m0_ack}, 2'b00);
    checkOutput("rst5_mem_kept", mem[8'h40], 8'h11);
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    reset = 1'b1;
    single_access(0, 1'b0, 8'h40, 8'h00, 8'h11);
    single_access(1, 1'b0, 8'h20, 8'h00, 8'hC3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
